mux_rr_arbiter_8: RTL and testbench

//  Round-robin arbiter sharing one N-bit output channel among 8 requesters.

---
 rtl/mux_rr_arbiter_8_if.sv | 31 +++
 rtl/mux_rr_arbiter_8.sv | 163 ++++++++++++++++
 tb/tb_mux_rr_arbiter_8.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_8_if.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_8_if
// Bundles the request, data, and output-channel signals of the 8-way
// round-robin arbiter.
//   master : the arbiter side. It takes req/d0..d7/out_ready and drives
//            out_valid/out_data/sel/gnt/busy.
//   slave  : the environment side, which covers the sources and the consumer.
// Parameter N : data width of each source and of out_data.
// ---------------------------------------------------------------------------
interface mux_rr_arbiter_8_if #(
  parameter int N = 4
);
  logic [7:0]   req;
  logic [N-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [2:0]   sel;
  logic [7:0]   gnt;
  logic         busy;

  modport master (
    input  req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
    output out_valid, out_data, sel, gnt, busy
  );

  modport slave (
    output req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
    input  out_valid, out_data, sel, gnt, busy
  );
endinterface

// File: rtl/mux_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_8
// Round-robin arbiter that shares one N-bit valid/ready output channel among
// 8 requesters. It picks a source, drives the 3-bit select of an internal 8:1
// data mux, and pulses a one-hot gnt when the beat of that source is consumed.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : mux_rr_arbiter_8_if.master
//         req[7:0], d0..d7, out_ready  (inputs)
//         out_valid, out_data, sel, gnt, busy (outputs)
//
// Parameters
//   N        : data width
//   HOLD_MAX : maximum number of back-to-back beats per grant (1..15).
//              This parameter is used only when burst hold is compiled in.
//
// Build option
//   `define ARB_HOLD_EN compiles in burst hold. A granted source that keeps
//   req high gets up to HOLD_MAX beats with no IDLE bubble between them.
// ---------------------------------------------------------------------------
module mux_rr_arbiter_8 #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_8_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] sel_reg, sel_next;
`ifdef ARB_HOLD_EN
  logic [3:0] cnt_reg, cnt_next;
`endif

  logic [N-1:0] d_arr [8];
  logic [2:0]   pick;
  logic         pick_valid;
  logic         in_grant;
  logic         req_sel;
  logic         out_valid;
  logic         transfer;
  logic [7:0]   gnt_vec;

  assign d_arr[0] = bus.d0;
  assign d_arr[1] = bus.d1;
  assign d_arr[2] = bus.d2;
  assign d_arr[3] = bus.d3;
  assign d_arr[4] = bus.d4;
  assign d_arr[5] = bus.d5;
  assign d_arr[6] = bus.d6;
  assign d_arr[7] = bus.d7;

  // The loop scans from the farthest index down to ptr so that the lowest
  // offset from ptr is written last and therefore wins.
  always_comb begin
    pick       = 3'd0;
    pick_valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_reg + 3'(k)]) begin
        pick       = ptr_reg + 3'(k);
        pick_valid = 1'b1;
      end
    end
  end

  // The outputs are masked by rst so that nothing is presented or granted
  // during the reset cycle, even when the arbiter was mid-transfer.
  assign in_grant  = (state_reg == GRANT) && !rst;
  assign req_sel   = bus.req[sel_reg];
  assign out_valid = in_grant & req_sel;
  assign transfer  = out_valid & bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_gnt
      assign gnt_vec[gi] = transfer & (sel_reg == 3'(gi));
    end
  endgenerate

  assign bus.out_valid = out_valid;
  assign bus.out_data  = d_arr[sel_reg];
  assign bus.sel       = sel_reg;
  assign bus.gnt       = gnt_vec;
  assign bus.busy      = in_grant;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
`ifdef ARB_HOLD_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          sel_next   = pick;
          state_next = GRANT;
`ifdef ARB_HOLD_EN
          cnt_next   = 4'd0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_HOLD_EN
        if (transfer) begin
          // The decision to stay is made at the transfer edge. The source
          // holds req high while it has more beats, so no bubble is needed.
          if ((cnt_reg + 4'd1) < 4'(HOLD_MAX)) begin
            cnt_next = cnt_reg + 4'd1;
          end else begin
            ptr_next   = sel_reg + 3'd1;
            state_next = IDLE;
          end
        end else if (!req_sel) begin
          // If the source drops req after at least one beat, that is a normal
          // release and ptr advances. If it drops req before any beat, that is
          // an abort and ptr keeps its value.
          if (cnt_reg != 4'd0) begin
            ptr_next = sel_reg + 3'd1;
          end
          state_next = IDLE;
        end
`else
        if (transfer) begin
          ptr_next   = sel_reg + 3'd1;
          state_next = IDLE;
        end else if (!req_sel) begin
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      sel_reg   <= 3'd0;
`ifdef ARB_HOLD_EN
      cnt_reg   <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
`ifdef ARB_HOLD_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter_8
// Directed bench for mux_rr_arbiter_8 with N=4 and HOLD_MAX=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge of the clock.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_8_if #(.N(4)) intf ();

  mux_rr_arbiter_8 #(.N(4), .HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  // These checks are evaluated on every falling edge.
  always @(negedge clk) begin
    tests_run++;
    if ($onehot0(intf.gnt) !== 1'b1) begin
      tests_failed++;
      $display("FAIL gnt_onehot: gnt=%h required one-hot or zero", intf.gnt);
    end
    tests_run++;
    if ((intf.gnt != 8'h00) && !(intf.out_valid && intf.out_ready)) begin
      tests_failed++;
      $display("FAIL gnt_qualified: gnt=%h out_valid=%b out_ready=%b required transfer",
               intf.gnt, intf.out_valid, intf.out_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    intf.req = 8'h00;
    intf.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_data;
    intf.d0 = 4'h1; intf.d1 = 4'h2; intf.d2 = 4'h3; intf.d3 = 4'h4;
    intf.d4 = 4'h5; intf.d5 = 4'h6; intf.d6 = 4'h7; intf.d7 = 4'h8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    intf.req = 8'hFF;
    intf.out_ready = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if ({intf.out_valid, intf.gnt, intf.busy, intf.sel} !== 13'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs: valid=%b gnt=%h busy=%b sel=%0d required all 0",
                 intf.out_valid, intf.gnt, intf.busy, intf.sel);
      end
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (intf.busy !== 1'b0 || intf.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b valid=%b required 0 0", intf.busy, intf.out_valid);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (intf.sel !== 3'd0 || intf.gnt !== 8'h01 || intf.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_grant: sel=%0d gnt=%h busy=%b required 0 01 1",
               intf.sel, intf.gnt, intf.busy);
    end
    step();
    intf.req = 8'h00;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single;
    reset_dut();
    set_data();
    intf.d3 = 4'hA;
    intf.req = 8'h08;
    intf.out_ready = 1'b1;
    step();
    @(negedge clk);
    tests_run++;
    if (intf.sel !== 3'd3 || intf.out_valid !== 1'b1 || intf.out_data !== 4'hA || intf.gnt !== 8'h08) begin
      tests_failed++;
      $display("FAIL single_beat: sel=%0d valid=%b data=%h gnt=%h required 3 1 a 08",
               intf.sel, intf.out_valid, intf.out_data, intf.gnt);
    end
    step();
    intf.req = 8'h00;
    @(negedge clk);
    tests_run++;
    if (intf.busy !== 1'b0 || intf.gnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b gnt=%h required 0 00", intf.busy, intf.gnt);
    end
    step();
    $display("[TB] test_single done");
  endtask

  task automatic test_rotation;
    logic [7:0] exp_gnt;
    reset_dut();
    set_data();
    intf.req = 8'hFF;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests_run++;
      if (intf.busy !== 1'b0 || intf.gnt !== 8'h00) begin
        tests_failed++;
        $display("FAIL rotation_idle[%0d]: busy=%b gnt=%h required 0 00", i, intf.busy, intf.gnt);
      end
      step();
      exp_gnt = 8'h01 << (i % 8);
      @(negedge clk);
      tests_run++;
      if (intf.sel !== 3'(i % 8) || intf.gnt !== exp_gnt) begin
        tests_failed++;
        $display("FAIL rotation_grant[%0d]: sel=%0d gnt=%h required %0d %h",
                 i, intf.sel, intf.gnt, i % 8, exp_gnt);
      end
      step();
    end
    intf.req = 8'h00;
    $display("[TB] test_rotation done");
  endtask

  task automatic test_backpressure;
    reset_dut();
    set_data();
    intf.req = 8'h20;
    intf.out_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (intf.out_valid !== 1'b1 || intf.sel !== 3'd5 || intf.out_data !== 4'h6 || intf.gnt !== 8'h00) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: valid=%b sel=%0d data=%h gnt=%h required 1 5 6 00",
                 c, intf.out_valid, intf.sel, intf.out_data, intf.gnt);
      end
      step();
    end
    intf.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (intf.gnt !== 8'h20) begin
      tests_failed++;
      $display("FAIL backpressure_release: gnt=%h required 20", intf.gnt);
    end
    step();
    intf.req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (intf.gnt !== 8'h00) begin
        tests_failed++;
        $display("FAIL backpressure_single_pulse[%0d]: gnt=%h required 00", c, intf.gnt);
      end
      step();
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_abort;
    reset_dut();
    set_data();
    intf.d5 = 4'hC;
    intf.req = 8'h24;
    intf.out_ready = 1'b0;
    step();
    @(negedge clk);
    tests_run++;
    if (intf.sel !== 3'd2 || intf.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_first_pick: sel=%0d valid=%b required 2 1", intf.sel, intf.out_valid);
    end
    step();
    intf.req = 8'h20;
    @(negedge clk);
    tests_run++;
    if (intf.out_valid !== 1'b0 || intf.gnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_drop: valid=%b gnt=%h required 0 00", intf.out_valid, intf.gnt);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (intf.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%b required 0", intf.busy);
    end
    step();
    intf.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (intf.sel !== 3'd5 || intf.out_data !== 4'hC || intf.gnt !== 8'h20) begin
      tests_failed++;
      $display("FAIL abort_next_grant: sel=%0d data=%h gnt=%h required 5 c 20",
               intf.sel, intf.out_data, intf.gnt);
    end
    step();
    intf.req = 8'h00;
    // ptr must not move on an abort. With req bits 0 and 5 and ptr still 0,
    // the arbiter must pick source 0.
    reset_dut();
    intf.req = 8'h24;
    step();
    intf.req = 8'h21;
    step();
    @(negedge clk);
    tests_run++;
    if (intf.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ptr_idle: busy=%b required 0", intf.busy);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (intf.sel !== 3'd0) begin
      tests_failed++;
      $display("FAIL abort_ptr_kept: sel=%0d required 0", intf.sel);
    end
    step();
    intf.req = 8'h00;
    $display("[TB] test_abort done");
  endtask

`ifdef ARB_HOLD_EN
  task automatic test_hold;
    reset_dut();
    set_data();
    intf.req = 8'h03;
    intf.out_ready = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      tests_run++;
      if (intf.gnt !== 8'h01) begin
        tests_failed++;
        $display("FAIL hold_src0[%0d]: gnt=%h required 01", b, intf.gnt);
      end
      step();
    end
    @(negedge clk);
    tests_run++;
    if (intf.busy !== 1'b0 || intf.gnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL hold_bubble: busy=%b gnt=%h required 0 00", intf.busy, intf.gnt);
    end
    step();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      tests_run++;
      if (intf.gnt !== 8'h02) begin
        tests_failed++;
        $display("FAIL hold_src1[%0d]: gnt=%h required 02", b, intf.gnt);
      end
      step();
    end
    intf.req = 8'h00;
    $display("[TB] test_hold done");
  endtask
`endif

  initial begin
    intf.req = 8'h00;
    intf.out_ready = 1'b0;
    set_data();
    test_reset();
    test_single();
`ifndef ARB_HOLD_EN
    test_rotation();
`endif
    test_backpressure();
    test_abort();
`ifdef ARB_HOLD_EN
    test_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
